// File: rtl/acc_group_sched.sv
// Per-layer sequencer for the accumulate/bias/ReLU stage: bias fetch, column window, drain per group.
// Optional busy-cycle counter on o_perf_cycles is built when ACC_GROUP_SCHED_PERF_EN is defined.
module acc_group_sched #(
    parameter int unsigned COL_W       = 16,
    parameter int unsigned GRP_W       = 8,
    parameter int unsigned BIAS_RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_layer1,
    input  logic [COL_W-1:0] i_cfg_fm_col,
    input  logic [GRP_W-1:0] i_cfg_grp_num,
    input  logic [15:0]      i_cfg_bias_base,
    output logic             o_bias_rd_en,
    output logic [15:0]      o_bias_addr,
    output logic             o_bias_load,
    output logic             o_col_en,
    input  logic             i_add4_valid,
    input  logic             i_add4_end,
    input  logic             i_out_valid,
    output logic [GRP_W-1:0] o_grp_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [31:0]      o_perf_cycles
);

    typedef enum logic [2:0] {
        StIdle,
        StBiasRd,
        StBiasWait,
        StRun,
        StDrain,
        StNext,
        StDone
    } state_e;

    localparam logic [2:0] LatLast = 3'(BIAS_RD_LAT - 1);

    state_e           state_q, state_d;
    logic [COL_W-1:0] fm_col_q, fm_col_d;
    logic [GRP_W-1:0] grp_num_q, grp_num_d;
    logic             layer1_q, layer1_d;
    logic [15:0]      addr_q, addr_d;
    logic [GRP_W-1:0] grp_idx_q, grp_idx_d;
    logic [COL_W-1:0] in_cnt_q, in_cnt_d;
    logic [COL_W-1:0] out_cnt_q, out_cnt_d;
    logic [COL_W-1:0] tgt_q, tgt_d;
    logic [2:0]       wait_q, wait_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic             start_ok;
    logic             in_take;
    logic             out_take;
    logic [COL_W-1:0] tgt_eff;
    logic [COL_W-1:0] in_nxt;
    logic [COL_W-1:0] out_nxt;
    logic             out_phase;

    always_comb begin
        state_d   = state_q;
        fm_col_d  = fm_col_q;
        grp_num_d = grp_num_q;
        layer1_d  = layer1_q;
        addr_d    = addr_q;
        grp_idx_d = grp_idx_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        tgt_d     = tgt_q;
        wait_d    = wait_q;
        err_d     = err_q;
        done_d    = 1'b0;

        // Start coincident with the done pulse is dropped as well as while busy.
        start_ok  = i_start && (state_q == StIdle) && !done_q;
        out_phase = (state_q == StRun) || (state_q == StDrain);
        // In RUN the drain target is not final yet, so the configured column count bounds outputs.
        tgt_eff   = (state_q == StRun) ? fm_col_q : tgt_q;
        in_take   = i_add4_valid && (state_q == StRun);
        out_take  = i_out_valid && out_phase && (out_cnt_q < tgt_eff);
        in_nxt    = in_take ? in_cnt_q + COL_W'(1) : in_cnt_q;
        out_nxt   = out_take ? out_cnt_q + COL_W'(1) : out_cnt_q;

        if (i_add4_valid && (state_q != StRun)) begin
            err_d = 1'b1;
        end
        if (i_out_valid && out_phase && (out_cnt_q >= tgt_eff)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    fm_col_d  = i_cfg_fm_col;
                    grp_num_d = i_cfg_grp_num;
                    layer1_d  = i_layer1;
                    grp_idx_d = '0;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    err_d     = 1'b0;
                    if ((i_cfg_fm_col == '0) || (i_cfg_grp_num == '0)) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = i_cfg_bias_base;
                        state_d = StBiasRd;
                    end
                end
            end
            StBiasRd: begin
                wait_d  = '0;
                state_d = StBiasWait;
            end
            StBiasWait: begin
                if (wait_q == LatLast) begin
                    state_d = StRun;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            StRun: begin
                in_cnt_d  = in_nxt;
                out_cnt_d = out_nxt;
                if (i_add4_end && !(in_take && (in_nxt == fm_col_q))) begin
                    // Misplaced end marker: drain only what was actually accepted.
                    err_d   = 1'b1;
                    tgt_d   = in_nxt;
                    state_d = StDrain;
                end else if (in_take && (in_nxt == fm_col_q)) begin
                    tgt_d   = fm_col_q;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                out_cnt_d = out_nxt;
                if (out_nxt >= tgt_q) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                grp_idx_d = grp_idx_q + GRP_W'(1);
                addr_d    = addr_q + (layer1_q ? 16'd32 : 16'd16);
                in_cnt_d  = '0;
                out_cnt_d = '0;
                tgt_d     = '0;
                if ((grp_idx_q + GRP_W'(1)) == grp_num_q) begin
                    state_d = StDone;
                end else begin
                    state_d = StBiasRd;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            fm_col_q  <= '0;
            grp_num_q <= '0;
            layer1_q  <= 1'b0;
            addr_q    <= '0;
            grp_idx_q <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            tgt_q     <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fm_col_q  <= fm_col_d;
            grp_num_q <= grp_num_d;
            layer1_q  <= layer1_d;
            addr_q    <= addr_d;
            grp_idx_q <= grp_idx_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            tgt_q     <= tgt_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign o_bias_rd_en = (state_q == StBiasRd);
    assign o_bias_addr  = addr_q;
    assign o_bias_load  = (state_q == StBiasWait) && (wait_q == LatLast);
    assign o_col_en     = (state_q == StRun);
    assign o_grp_idx    = grp_idx_q;
    assign o_busy       = (state_q != StIdle);
    assign o_done       = done_q;
    assign o_err        = err_q;

`ifdef ACC_GROUP_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (start_ok) begin
            perf_q <= '0;
        end else if (o_busy) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign o_perf_cycles = perf_q;
`else
    assign o_perf_cycles = '0;
`endif

endmodule
